fifo_stream_reader: RTL and testbench

- Consumer-side adapter for the read/write-enable FIFO read port (read_enable / read_data / empty, first-word-fall-through: read_data is valid whenever empty is low).
- Pops words from the FIFO and presents them on a registered valid/ready stream output.
- Two-entry holding buffer (main + skid) sustains one word per cycle with no combinational path from output_ready to fifo_read_enable.
- Sits between any FIFO in the data library and valid/ready consumers.

---
 rtl/fifo_stream_reader.sv | 146 ++++++++++++++
 tb/tb_fifo_stream_reader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// fifo_stream_reader
//
// Purpose:
//   Consumer-side adapter for a first-word-fall-through FIFO read port.
//   It pops words from the FIFO and presents them on a registered valid/ready
//   stream. A two-entry holding buffer (main + skid) sustains one word per
//   cycle. fifo_read_enable depends only on registered state, fifo_empty and
//   resetn. There is no combinational path from output_ready to the FIFO pop.
//
// Parameters:
//   WIDTH             data word width in bits (default 8)
//
// Ports:
//   clock             in   system clock, rising edge
//   resetn            in   asynchronous active-low reset
//   fifo_read_enable  out  pop strobe to the FIFO read port
//   fifo_read_data    in   FIFO head word, valid while fifo_empty=0
//   fifo_empty        in   FIFO empty flag
//   output_valid      out  stream word available
//   output_data       out  stream word
//   output_ready      in   consumer accepts word
//   occupancy         out  number of held words, 0..2
//                          (present only with FIFO_STREAM_READER_OCCUPANCY_EN)
//
// Optional build macro:
//   FIFO_STREAM_READER_OCCUPANCY_EN
//     Adds the occupancy port and simulation-only assertions. The assertions
//     check that no pop happens while the FIFO is empty, and that output_data
//     is held stable while the output is stalled. The datapath is the same
//     whether or not the macro is defined.
// -----------------------------------------------------------------------------
module fifo_stream_reader #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             resetn,
  output logic             fifo_read_enable,
  input  logic [WIDTH-1:0] fifo_read_data,
  input  logic             fifo_empty,
  output logic             output_valid,
  output logic [WIDTH-1:0] output_data,
  input  logic             output_ready
`ifdef FIFO_STREAM_READER_OCCUPANCY_EN
  ,
  output logic [1:0]       occupancy
`endif
);

  // The encoding equals the number of held words, so occupancy is simply
  // the state register.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] main_reg,  main_next;
  logic [WIDTH-1:0] skid_reg,  skid_next;
  logic             pop;
  logic             transfer;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg <= EMPTY;
      main_reg  <= '0;
      skid_reg  <= '0;
    end else begin
      state_reg <= state_next;
      main_reg  <= main_next;
      skid_reg  <= skid_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
    skid_next  = skid_reg;
    case (state_reg)
      EMPTY: begin
        if (pop) begin
          state_next = ONE;
          main_next  = fifo_read_data;
        end
      end
      ONE: begin
        if (pop && transfer) begin
          main_next = fifo_read_data;
        end else if (pop) begin
          // The consumer stalled while a new word arrived, so the new word
          // waits in the skid register behind the one in main.
          state_next = TWO;
          skid_next  = fifo_read_data;
        end else if (transfer) begin
          state_next = EMPTY;
        end
      end
      TWO: begin
        // No pop is possible here. The skid word moves forward once the
        // consumer takes the main word.
        if (transfer) begin
          state_next = ONE;
          main_next  = skid_reg;
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // resetn gates the pop so that no word leaves the FIFO during reset,
    // when the state register cannot capture it.
    fifo_read_enable = resetn && !fifo_empty && (state_reg != TWO);
    output_valid     = (state_reg != EMPTY);
    output_data      = main_reg;
    pop              = fifo_read_enable;
    transfer         = output_valid && output_ready;
  end

`ifdef FIFO_STREAM_READER_OCCUPANCY_EN
  assign occupancy = 2'(state_reg);

  a_no_pop_when_empty : assert property (
    @(posedge clock) disable iff (!resetn)
    fifo_empty |-> !fifo_read_enable
  );

  a_stall_stable : assert property (
    @(posedge clock) disable iff (!resetn)
    (output_valid && !output_ready) |=> (output_valid && $stable(output_data))
  );
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_stream_reader
//
// Purpose:
//   Self-checking bench for fifo_stream_reader. It uses directed cycle tables
//   with hand-computed expected values. It also keeps a queue-based model of
//   the FIFO contents and of the words held by the reader.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_fifo_stream_reader;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         resetn;
  logic         fifo_read_enable;
  logic [W-1:0] fifo_read_data;
  logic         fifo_empty;
  logic         output_valid;
  logic [W-1:0] output_data;
  logic         output_ready;
`ifdef FIFO_STREAM_READER_OCCUPANCY_EN
  logic [1:0]   occupancy;
`endif

  fifo_stream_reader #(.WIDTH(W)) dut (
    .clock            (clock),
    .resetn           (resetn),
    .fifo_read_enable (fifo_read_enable),
    .fifo_read_data   (fifo_read_data),
    .fifo_empty       (fifo_empty),
    .output_valid     (output_valid),
    .output_data      (output_data),
    .output_ready     (output_ready)
`ifdef FIFO_STREAM_READER_OCCUPANCY_EN
    ,
    .occupancy        (occupancy)
`endif
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // FIFO contents (head at index 0) and words the reader should hold.
  logic [W-1:0] fifo_q[$];
  logic [W-1:0] held_q[$];

  // Values sampled in the current cycle, before the rising edge.
  logic         s_re, s_valid, s_ready, s_empty;
  logic [W-1:0] s_data, s_word;

  int t2_re[6] = '{1, 1, 1, 1, 0, 0};
  int t2_v [6] = '{0, 1, 1, 1, 1, 0};
  int t2_d [6] = '{0, 'h11, 'h22, 'h33, 'h44, 0};

  int t3_rdy[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 1};
  int t3_re [9] = '{1, 1, 0, 0, 0, 1, 1, 0, 0};
  int t3_v  [9] = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
  int t3_d  [9] = '{0, 'h11, 'h11, 'h11, 'h11, 'h22, 'h33, 'h44, 0};

  task automatic check_value(input string tag, input logic [31:0] act,
                             input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic preload(input int n, input int base, input int stride);
    fifo_q.delete();
    for (int i = 0; i < n; i++) fifo_q.push_back(W'(base + i * stride));
  endtask

  // Called just after a falling edge. It drives the inputs, samples the
  // outputs and compares them against the model.
  task automatic drive(input bit rdy, input bit gate);
    fifo_empty     = gate || (fifo_q.size() == 0);
    fifo_read_data = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    output_ready   = rdy;
    #1;
    s_re    = fifo_read_enable;
    s_valid = output_valid;
    s_data  = output_data;
    s_empty = fifo_empty;
    s_ready = rdy;
    s_word  = fifo_read_data;
    check_value("model_valid", s_valid, held_q.size() != 0);
    if (held_q.size() != 0) check_value("model_data", s_data, held_q[0]);
    check_value("model_rd_en", s_re, !s_empty && (held_q.size() < 2));
  endtask

  // Crosses the rising edge, applies the pop/transfer to the model, and
  // returns on the falling edge.
  task automatic advance();
    @(posedge clock);
    if (s_valid && s_ready && held_q.size() != 0) void'(held_q.pop_front());
    if (s_re && !s_empty && fifo_q.size() != 0) begin
      held_q.push_back(s_word);
      void'(fifo_q.pop_front());
    end
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pops, n_xfer, first_x, last_x, exp_val, pushed, delivered, guard;

    // ---- Reset and idle --------------------------------------------------
    resetn         = 1'b0;
    fifo_empty     = 1'b1;
    fifo_read_data = '0;
    output_ready   = 1'b0;
    #1;
    fifo_empty = 1'b0;
    #1;
    check_value("rst_rd_en", fifo_read_enable, 0);
    check_value("rst_valid", output_valid, 0);
    check_value("rst_data",  output_data, 0);
    fifo_empty = 1'b1;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    held_q.delete();
    fifo_q.delete();

    for (int c = 0; c < 10; c++) begin
      drive(c[0], 1'b1);   // output_ready toggles and must be ignored
      check_value($sformatf("idle_valid[%0d]", c), s_valid, 0);
      check_value($sformatf("idle_rd_en[%0d]", c), s_re, 0);
      check_value($sformatf("idle_data[%0d]",  c), s_data, 0);
      advance();
    end

    // ---- Preload 4, output_ready=1 ---------------------------------------
    preload(4, 'h11, 'h11);
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 1'b0);
      check_value($sformatf("t2_rd_en[%0d]", c), s_re, t2_re[c]);
      check_value($sformatf("t2_valid[%0d]", c), s_valid, t2_v[c]);
      if (t2_v[c] != 0) check_value($sformatf("t2_data[%0d]", c), s_data, t2_d[c]);
      advance();
    end

    // ---- Preload 4, stall then release -----------------------------------
    preload(4, 'h11, 'h11);
    pops = 0;
    for (int c = 0; c < 9; c++) begin
      drive(t3_rdy[c] != 0, 1'b0);
      if (c < 4) pops += int'(s_re);
      check_value($sformatf("t3_rd_en[%0d]", c), s_re, t3_re[c]);
      check_value($sformatf("t3_valid[%0d]", c), s_valid, t3_v[c]);
      if (t3_v[c] != 0) check_value($sformatf("t3_data[%0d]", c), s_data, t3_d[c]);
      advance();
    end
    check_value("t3_stall_pops", pops, 2);

    // ---- Back-to-back 100 words ------------------------------------------
    preload(100, 0, 1);
    n_xfer = 0; first_x = -1; last_x = -1; exp_val = 0;
    for (int c = 0; c < 130 && n_xfer < 100; c++) begin
      drive(1'b1, 1'b0);
      if (s_valid) begin
        if (first_x < 0) first_x = c;
        last_x = c;
        n_xfer++;
        check_value("b2b_data", s_data, exp_val);
        exp_val++;
      end
      advance();
    end
    check_value("b2b_count", n_xfer, 100);
    check_value("b2b_first", first_x, 1);
    check_value("b2b_span", last_x - first_x, 99);
    drive(1'b1, 1'b0);
    check_value("b2b_drained", s_valid, 0);
    advance();

    // ---- Random empty/ready against the model ----------------------------
    fifo_q.delete();
    pushed = 0; delivered = 0;
    for (int c = 0; c < 1000; c++) begin
      if ($urandom_range(0, 1) != 0) begin
        fifo_q.push_back(W'($urandom_range(0, 255)));
        pushed++;
      end
      drive($urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0);
      if (s_valid && s_ready) delivered++;
      advance();
    end
    guard = 0;
    while ((fifo_q.size() != 0 || held_q.size() != 0) && guard < 1200) begin
      drive(1'b1, 1'b0);
      if (s_valid && s_ready) delivered++;
      advance();
      guard++;
    end
    check_value("rand_drain_bound", guard < 1200, 1);
    check_value("rand_delivered", delivered, pushed);

    // ---- Asynchronous reset while in TWO ---------------------------------
    preload(4, 'hA0, 1);
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, 1'b0);
      advance();
    end
    drive(1'b0, 1'b0);
    check_value("two_data", s_data, 'hA0);
    check_value("two_rd_en", s_re, 0);
    resetn = 1'b0;
    #1;
    check_value("arst_valid", output_valid, 0);
    check_value("arst_rd_en", fifo_read_enable, 0);
    check_value("arst_data",  output_data, 0);
    held_q.delete();
    @(negedge clock);
    resetn = 1'b1;
    drive(1'b1, 1'b0);
    check_value("post_rst_valid", s_valid, 0);
    check_value("post_rst_rd_en", s_re, 1);
    advance();
    drive(1'b1, 1'b0);
    check_value("post_rst_first", s_data, 'hA2);
    check_value("post_rst_vld", s_valid, 1);
    advance();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
